spd_info_frame_receiver: RTL and testbench

SPD_INFO_FRAME_RECEIVER -- requirements
Module: spd_info_frame_receiver

---
 rtl/hdmi_info_frame_pkg.sv | 26 ++
 rtl/info_frame_byte_collector.sv | 116 +++++++++++
 rtl/spd_info_frame_receiver.sv | 60 ++++++
 tb/tb_spd_info_frame_receiver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_info_frame_pkg.sv
// Shared definitions for HDMI InfoFrame receivers (SPD, AVI, audio).
package hdmi_info_frame_pkg;

  localparam logic [7:0] IF_TYPE_AVI   = 8'd2;
  localparam logic [7:0] IF_TYPE_SPD   = 8'd3;
  localparam logic [7:0] IF_TYPE_AUDIO = 8'd4;

  localparam int unsigned HDR_BYTES  = 3;
  localparam int unsigned PKT_BYTES  = 31;
  localparam int unsigned MAX_LENGTH = 27;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_CHECKSUM     = 2'd1,
    ERR_TYPE_VERSION = 2'd2,
    ERR_LENGTH_ABORT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_e;

endpackage

// File: rtl/info_frame_byte_collector.sv
// Generic InfoFrame byte collector: framing FSM, byte index, checksum, and
// a committed copy of the last packet that passed all checks.
module info_frame_byte_collector
  import hdmi_info_frame_pkg::*;
#(
  parameter logic [7:0] EXPECTED_TYPE    = 8'h83,
  parameter logic [7:0] EXPECTED_VERSION = 8'h01
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic [PKT_BYTES-1:0][7:0]     frame,
  output logic                          pkt_valid,
  output logic                          pkt_error,
  output err_code_e                     err_code
);

  rx_state_e                    state, state_next;
  logic [4:0]                   idx, idx_next, wr_idx;
  logic [7:0]                   csum, csum_next, sum_acc;
  logic [PKT_BYTES-1:0][7:0]    work;
  logic [4:0]                   length;
  logic                         include_byte, start, wr_en;
  logic                         res_set, res_good;
  err_code_e                    res_err;

  assign start  = in_valid & in_start;
  assign length = work[2][4:0];
  // Header bytes always count; payload byte PBn (idx = n+3) only while n <= LENGTH.
  assign include_byte = (state == ST_HEADER) ||
                        ({1'b0, idx} <= ({1'b0, length} + 6'd3));
  assign sum_acc = csum + (include_byte ? in_byte : 8'h00);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    csum_next  = csum;
    wr_en      = 1'b0;
    wr_idx     = idx;
    res_set    = 1'b0;
    res_good   = 1'b0;
    res_err    = ERR_NONE;
    case (state)
      ST_IDLE, ST_CHECK: begin
        state_next = ST_IDLE;
        if (start) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          idx_next   = 5'd1;
          csum_next  = in_byte;
          state_next = ST_HEADER;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (start) begin
          // A new HB0 mid-packet aborts the old one and starts over at once.
          res_set    = 1'b1;
          res_err    = ERR_LENGTH_ABORT;
          wr_en      = 1'b1;
          wr_idx     = '0;
          idx_next   = 5'd1;
          csum_next  = in_byte;
          state_next = ST_HEADER;
        end else if (in_valid) begin
          wr_en     = 1'b1;
          idx_next  = idx + 5'd1;
          csum_next = sum_acc;
          if (state == ST_HEADER && idx == 5'(HDR_BYTES - 1))
            state_next = ST_PAYLOAD;
          if (state == ST_PAYLOAD && idx == 5'(PKT_BYTES - 1)) begin
            state_next = ST_CHECK;
            res_set    = 1'b1;
            if (length > 5'(MAX_LENGTH))
              res_err = ERR_LENGTH_ABORT;
            else if (work[0] != EXPECTED_TYPE || work[1] != EXPECTED_VERSION)
              res_err = ERR_TYPE_VERSION;
            else if (sum_acc != 8'h00)
              res_err = ERR_CHECKSUM;
            else
              res_good = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      csum      <= '0;
      work      <= '0;
      frame     <= '0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      csum      <= csum_next;
      pkt_valid <= res_set & res_good;
      pkt_error <= res_set & ~res_good;
      if (wr_en)
        work[wr_idx] <= in_byte;
      if (res_set)
        err_code <= res_err;
      // PB27 is still on in_byte when the verdict lands, so commit it directly.
      if (res_set && res_good)
        frame <= {in_byte, work[PKT_BYTES-2:0]};
    end
  end

endmodule

// File: rtl/spd_info_frame_receiver.sv
// SPD InfoFrame receiver: generic byte collector plus SPD field decode of
// the last good packet.
module spd_info_frame_receiver
  import hdmi_info_frame_pkg::*;
#(
  parameter logic [7:0] EXPECTED_TYPE    = 8'h83,
  parameter logic [7:0] EXPECTED_VERSION = 8'h01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic [23:0]       header,
  output logic [3:0][55:0]  sub,
  output logic [63:0]       vendor_name,
  output logic [127:0]      product_description,
  output logic [7:0]        source_device_information,
  output logic              pkt_valid,
  output logic              pkt_error,
  output logic [1:0]        err_code
);

  logic [PKT_BYTES-1:0][7:0] frame;
  err_code_e                 err_w;

  info_frame_byte_collector #(
    .EXPECTED_TYPE    (EXPECTED_TYPE),
    .EXPECTED_VERSION (EXPECTED_VERSION)
  ) u_collector (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_start  (in_start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .frame     (frame),
    .pkt_valid (pkt_valid),
    .pkt_error (pkt_error),
    .err_code  (err_w)
  );

  assign err_code = err_w;

  // frame[0..2] = HB0..HB2, frame[3+n] = PBn.
  always_comb begin
    header                    = {frame[2], frame[1], frame[0]};
    sub                       = '0;
    vendor_name               = '0;
    product_description       = '0;
    source_device_information = frame[28];
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned b = 0; b < 7; b++)
        sub[i][8*b +: 8] = frame[3 + 7*i + b];
    for (int unsigned k = 0; k < 8; k++)
      vendor_name[63 - 8*k -: 8] = frame[4 + k];
    for (int unsigned k = 0; k < 16; k++)
      product_description[127 - 8*k -: 8] = frame[12 + k];
  end

endmodule

// File: tb/tb_spd_info_frame_receiver.sv
// Scoreboard bench for spd_info_frame_receiver: directed packets push expected
// results; a negedge monitor pops and compares on every result pulse.
module tb_spd_info_frame_receiver;

  typedef logic [30:0][7:0] pkt_t;

  typedef struct {
    logic              v;
    logic [1:0]        err;
    int                cyc;
    logic [23:0]       hdr;
    logic [3:0][55:0]  sub;
    logic [63:0]       vn;
    logic [127:0]      pd;
    logic [7:0]        sdi;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_start, in_valid;
  logic [7:0]        in_byte;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic [63:0]       vendor_name;
  logic [127:0]      product_description;
  logic [7:0]        source_device_information;
  logic              pkt_valid, pkt_error;
  logic [1:0]        err_code;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t last_good;

  spd_info_frame_receiver #(
    .EXPECTED_TYPE    (8'h83),
    .EXPECTED_VERSION (8'h01)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .in_start                  (in_start),
    .in_valid                  (in_valid),
    .in_byte                   (in_byte),
    .header                    (header),
    .sub                       (sub),
    .vendor_name               (vendor_name),
    .product_description       (product_description),
    .source_device_information (source_device_information),
    .pkt_valid                 (pkt_valid),
    .pkt_error                 (pkt_error),
    .err_code                  (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs straight from the field definitions (PBn = p[3+n]).
  function automatic exp_t decode(input pkt_t p);
    exp_t e;
    e.v   = 1'b0;
    e.err = 2'd0;
    e.cyc = 0;
    e.hdr = {p[2], p[1], p[0]};
    e.sub = '0;
    e.vn  = '0;
    e.pd  = '0;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 7; b++)
        e.sub[i][8*b +: 8] = p[3 + 7*i + b];
    for (int k = 0; k < 8; k++)  e.vn[63 - 8*k -: 8]  = p[4 + k];
    for (int k = 0; k < 16; k++) e.pd[127 - 8*k -: 8] = p[12 + k];
    e.sdi = p[28];
    return e;
  endfunction

  function automatic pkt_t mk(input logic [7:0] hb0, hb1, hb2, pb0, pb1, pb25);
    pkt_t p = '0;
    p[0] = hb0; p[1] = hb1; p[2] = hb2;
    p[3] = pb0; p[4] = pb1; p[28] = pb25;
    return p;
  endfunction

  task automatic push(input logic v, input logic [1:0] err, input pkt_t p);
    exp_t e;
    if (v) last_good = decode(p);
    e     = last_good;
    e.v   = v;
    e.err = err;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s, input int gaps);
    repeat (gaps) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_start = s;
    in_byte  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  // Sends the first n bytes of p; a full packet pushes its verdict, and
  // abort_prev pushes the abort error raised by this packet's HB0.
  task automatic send_pkt(input pkt_t p, input int n, input int gmax, input logic abort_prev,
                          input logic v, input logic [1:0] err);
    for (int i = 0; i < n; i++) begin
      send_byte(p[i], i == 0, gmax > 0 ? int'($urandom_range(1, gmax)) : 0);
      if (i == 0 && abort_prev) push(1'b0, 2'd3, p);
      if (i == 30) push(v, err, p);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pkt_valid"}, pkt_valid, 0);
    chk({tag, "_pkt_error"}, pkt_error, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_header"}, header, 0);
    chk({tag, "_sub"}, sub, 0);
    chk({tag, "_vendor"}, vendor_name, 0);
    chk({tag, "_product"}, product_description, 0);
    chk({tag, "_sdi"}, source_device_information, 0);
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: got none expected pulse at cycle %0d (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (pkt_valid || pkt_error) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none (cycle %0d)",
                 pkt_valid, pkt_error, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {pkt_valid, pkt_error}, {e.v, ~e.v});
        chk("err_code", err_code, e.err);
        chk("latency", cyc, e.cyc);
        chk("header", header, e.hdr);
        chk("sub", sub, e.sub);
        chk("vendor_name", vendor_name, e.vn);
        chk("product_description", product_description, e.pd);
        chk("source_device_information", source_device_information, e.sdi);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t pa, pb, pcs, pty, pc, p27, p28;
    pa  = mk(8'h83, 8'h01, 8'h19, 8'h21, 8'h41, 8'h01);
    pcs = mk(8'h83, 8'h01, 8'h19, 8'h22, 8'h41, 8'h01);
    pty = mk(8'h82, 8'h01, 8'h19, 8'h22, 8'h41, 8'h01);
    pb  = mk(8'h83, 8'h01, 8'h19, 8'h20, 8'h42, 8'h01);
    pc  = pa;
    pc[29] = 8'h77;                         // PB26/PB27 beyond LENGTH 25: not summed
    pc[30] = 8'h88;
    p27 = mk(8'h83, 8'h01, 8'h1B, 8'h5C, 8'h00, 8'h00);
    p27[30] = 8'h05;                        // LENGTH 27: PB27 is summed
    p28 = mk(8'h83, 8'h01, 8'h1C, 8'h21, 8'h41, 8'h01);

    last_good = decode('0);
    reset_n  = 1'b0;
    in_start = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    idle(2);
    check_zero("post_reset");

    send_pkt(pa, 31, 0, 1'b0, 1'b1, 2'd0);
    idle(3);
    chk("good_vendor_msb", vendor_name[63:56], 8'h41);
    chk("good_sdi", source_device_information, 8'h01);
    chk("good_err_hold", err_code, 2'd0);

    send_pkt(pcs, 31, 0, 1'b0, 1'b0, 2'd1);
    idle(3);
    chk("cs_err_hold", err_code, 2'd1);
    chk("cs_vendor_kept", vendor_name[63:56], 8'h41);

    send_pkt(pty, 31, 0, 1'b0, 1'b0, 2'd2);
    idle(3);

    send_pkt(pa, 13, 0, 1'b0, 1'b0, 2'd0);  // HB0..PB9, then in_start at PB10
    send_pkt(pb, 31, 0, 1'b1, 1'b1, 2'd0);
    idle(3);

    send_pkt(pa, 31, 5, 1'b0, 1'b1, 2'd0);
    idle(3);
    send_pkt(pc, 31, 0, 1'b0, 1'b1, 2'd0);
    idle(3);
    send_pkt(p27, 31, 0, 1'b0, 1'b1, 2'd0);
    idle(3);
    send_pkt(p28, 31, 0, 1'b0, 1'b0, 2'd3);
    idle(3);

    send_pkt(pb, 31, 0, 1'b0, 1'b1, 2'd0);  // next HB0 lands while in CHECK
    send_pkt(pa, 31, 0, 1'b0, 1'b1, 2'd0);
    idle(3);

    send_pkt(pb, 19, 0, 1'b0, 1'b0, 2'd0);  // up to PB15, then reset
    @(negedge clk);
    in_valid  = 1'b0;
    in_start  = 1'b0;
    reset_n   = 1'b0;
    last_good = decode('0);
    repeat (2) @(negedge clk);
    check_zero("mid_reset");
    reset_n = 1'b1;
    idle(3);
    check_zero("after_mid_reset");
    for (int i = 0; i < 4; i++) send_byte(8'h83, 1'b0, 0);   // no in_start: ignored
    idle(3);
    check_zero("no_start");
    send_pkt(pa, 31, 0, 1'b0, 1'b1, 2'd0);
    idle(6);

    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
